decrementer_top_module: RTL and testbench

DECREMENTER_TOP_MODULE -- requirements
Module: decrementer_top_module

---
 rtl/decrementer_top_module.sv | 70 +++++++
 tb/tb_decrementer_top_module.sv | 130 +++++++++++++
 2 files changed

// File: rtl/decrementer_top_module.sv
// Registered decrement-by-one of a selected operand, reported in sign-magnitude form.
// One result per valid cycle. An operand of 0 yields magnitude 1 with the negative flag set.

module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);
    assign d    = a ^ b;
    assign bout = ~a & b;
endmodule

module decrementer_top_module #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sel,
    input  logic             In_Valid,
    output logic [WIDTH-1:0] Out,
    output logic             Negative_Sign_Flag,
    output logic             Zero_Flag,
    output logic             Out_Valid
);
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] mag;
    logic             is_zero;

    assign operand = Sel ? B : A;

    // Injecting a borrow of 1 into stage 0 subtracts the constant 1.
    assign borrow[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_chain
            half_subtractor u_hs (
                .a    (operand[i]),
                .b    (borrow[i]),
                .d    (diff[i]),
                .bout (borrow[i+1])
            );
        end
    endgenerate

    // A final borrow can only come from operand 0, where diff is all-ones; negating it gives magnitude 1.
    assign mag     = borrow[WIDTH] ? (~diff + {{(WIDTH-1){1'b0}}, 1'b1}) : diff;
    assign is_zero = ~borrow[WIDTH] & (diff == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Out                <= '0;
            Negative_Sign_Flag <= 1'b0;
            Zero_Flag          <= 1'b0;
            Out_Valid          <= 1'b0;
        end else begin
            Out_Valid <= In_Valid;
            if (In_Valid) begin
                Out                <= mag;
                Negative_Sign_Flag <= borrow[WIDTH];
                Zero_Flag          <= is_zero;
            end
        end
    end
endmodule

// File: tb/tb_decrementer_top_module.sv
// Directed bench for decrementer_top_module. Expected results are queued when a valid input is
// driven and popped when the result is due; between results, held values are checked.

module tb_decrementer_top_module;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] out;
        logic         neg;
        logic         zero;
    } res_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] A, B;
    logic         Sel, In_Valid;
    logic [W-1:0] Out;
    logic         Negative_Sign_Flag, Zero_Flag, Out_Valid;

    int   n_asserts = 0;
    int   n_fails   = 0;
    res_t q[$];
    res_t held;

    decrementer_top_module #(.WIDTH(W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .A                  (A),
        .B                  (B),
        .Sel                (Sel),
        .In_Valid           (In_Valid),
        .Out                (Out),
        .Negative_Sign_Flag (Negative_Sign_Flag),
        .Zero_Flag          (Zero_Flag),
        .Out_Valid          (Out_Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] op);
        res_t r;
        if (op == '0) begin
            r.out  = 1;
            r.neg  = 1'b1;
            r.zero = 1'b0;
        end else begin
            r.out  = op - 1'b1;
            r.neg  = 1'b0;
            r.zero = (op == 1);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then check all outputs 1 time unit after the edge.
    task automatic cycle(input logic r, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic v, input string tag);
        rst_n = r; Sel = s; A = a; B = b; In_Valid = v;
        if (r && v) q.push_back(model(s ? b : a));
        @(posedge clk);
        #1;
        if (!r) begin
            held.out = '0; held.neg = 1'b0; held.zero = 1'b0;
        end else if (v) begin
            if (q.size() == 0) begin
                n_asserts++;
                n_fails++;
                $error("FAIL %s_queue: observed empty expected entry", tag);
            end else begin
                held = q.pop_front();
            end
        end
        chk({tag, "_vld"},  {{(W-1){1'b0}}, Out_Valid},          {{(W-1){1'b0}}, r & v});
        chk({tag, "_out"},  Out,                                  held.out);
        chk({tag, "_neg"},  {{(W-1){1'b0}}, Negative_Sign_Flag}, {{(W-1){1'b0}}, held.neg});
        chk({tag, "_zero"}, {{(W-1){1'b0}}, Zero_Flag},          {{(W-1){1'b0}}, held.zero});
    endtask

    initial begin
        held.out = '0; held.neg = 1'b0; held.zero = 1'b0;
        rst_n = 1'b0; Sel = 1'b0; A = '0; B = '0; In_Valid = 1'b0;

        // Reset, then idle cycles must keep reset values.
        cycle(1'b0, 1'b0, 4'd3, 4'd0, 1'b1, "reset0");
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, "reset1");
        cycle(1'b1, 1'b0, 4'd9, 4'd9, 1'b0, "idle_after_reset");

        // Sweep A with Sel=0, back to back.
        for (int i = 0; i < 16; i++)
            cycle(1'b1, 1'b0, W'(i), 4'd0, 1'b1, $sformatf("selA_%0d", i));

        // Sweep B with Sel=1, back to back.
        for (int i = 0; i < 16; i++)
            cycle(1'b1, 1'b1, 4'd0, W'(i), 1'b1, $sformatf("selB_%0d", i));

        // Unselected operand has no effect.
        cycle(1'b1, 1'b1, 4'b0101, 4'b1010, 1'b1, "sel_b_10");
        cycle(1'b1, 1'b1, 4'b0000, 4'b1010, 1'b1, "sel_b_10_a_changed");
        cycle(1'b1, 1'b0, 4'b0011, 4'b1111, 1'b1, "sel_a_3");
        cycle(1'b1, 1'b0, 4'b0011, 4'b0000, 1'b1, "sel_a_3_b_changed");

        // Valid then invalid: Out_Valid drops, result holds while inputs move.
        cycle(1'b1, 1'b0, 4'd1, 4'd0, 1'b1, "valid_zero_flag");
        cycle(1'b1, 1'b0, 4'd12, 4'd7, 1'b0, "hold_1");
        cycle(1'b1, 1'b1, 4'd0, 4'd0, 1'b0, "hold_2");
        cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, "neg_after_hold");

        // Reset wins over a simultaneous valid input; first valid after release captures.
        cycle(1'b0, 1'b0, 4'b0111, 4'd0, 1'b1, "reset_vs_valid");
        cycle(1'b1, 1'b0, 4'b0111, 4'd0, 1'b1, "first_after_reset");
        cycle(1'b1, 1'b0, 4'b0111, 4'd0, 1'b0, "tail");

        n_asserts++;
        assert (q.size() == 0) else begin
            n_fails++;
            $error("FAIL scoreboard_drain: observed %0d leftover expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
